// File: rtl/id_exe_reg.sv
// rtl/id_exe_reg.sv - decode-to-execute pipeline register with freeze, flush and debug counters
//
// Purpose:
//   Captures decoded operands and control from the decode stage each cycle and
//   presents them to the execute stage (ALU, val2 generator, branch adder).
//   A flush replaces the slot with a bubble, a freeze holds it, and two
//   saturating counters record inserted bubbles and frozen cycles.
//
// Ports:
//   clk, rst                  core clock (rising edge), asynchronous active-low reset
//   freeze, flush             hazard stall hold / taken-branch bubble insert
//   valid_in, valid_out       slot holds a real instruction
//   *_in / *_out              decoded operands and control, one cycle latency
//   is_mem_cmd_out            mem_r_en_out | mem_w_en_out
//   bubble_cnt, stall_cnt     saturating event counters

module id_exe_reg #(
  parameter int WORD_WIDTH            = 32,
  parameter int SHIFTER_OPERAND_WIDTH = 12,
  parameter int REG_ADDR_WIDTH        = 4,
  parameter int EXE_CMD_WIDTH         = 4,
  parameter int CNT_WIDTH             = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             freeze,
  input  logic                             flush,
  input  logic                             valid_in,
  input  logic [WORD_WIDTH-1:0]            pc_in,
  input  logic [WORD_WIDTH-1:0]            val_rn_in,
  input  logic [WORD_WIDTH-1:0]            val_rm_in,
  input  logic [SHIFTER_OPERAND_WIDTH-1:0] shift_operand_in,
  input  logic                             imm_in,
  input  logic [23:0]                      signed_imm24_in,
  input  logic [REG_ADDR_WIDTH-1:0]        dest_in,
  input  logic [REG_ADDR_WIDTH-1:0]        src1_in,
  input  logic [REG_ADDR_WIDTH-1:0]        src2_in,
  input  logic [EXE_CMD_WIDTH-1:0]         exe_cmd_in,
  input  logic                             mem_r_en_in,
  input  logic                             mem_w_en_in,
  input  logic                             wb_en_in,
  input  logic                             b_in,
  input  logic                             s_in,
  input  logic                             carry_in,
  output logic                             valid_out,
  output logic [WORD_WIDTH-1:0]            pc_out,
  output logic [WORD_WIDTH-1:0]            val_rn_out,
  output logic [WORD_WIDTH-1:0]            val_rm_out,
  output logic [SHIFTER_OPERAND_WIDTH-1:0] shift_operand_out,
  output logic                             imm_out,
  output logic [23:0]                      signed_imm24_out,
  output logic [REG_ADDR_WIDTH-1:0]        dest_out,
  output logic [REG_ADDR_WIDTH-1:0]        src1_out,
  output logic [REG_ADDR_WIDTH-1:0]        src2_out,
  output logic [EXE_CMD_WIDTH-1:0]         exe_cmd_out,
  output logic                             mem_r_en_out,
  output logic                             mem_w_en_out,
  output logic                             wb_en_out,
  output logic                             b_out,
  output logic                             s_out,
  output logic                             carry_out,
  output logic                             is_mem_cmd_out,
  output logic [CNT_WIDTH-1:0]             bubble_cnt,
  output logic [CNT_WIDTH-1:0]             stall_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Flush takes priority over freeze so a squashed instruction can never be
  // held in the slot; a frozen bubble stays a bubble because nothing reloads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out         <= 1'b0;
      pc_out            <= '0;
      val_rn_out        <= '0;
      val_rm_out        <= '0;
      shift_operand_out <= '0;
      imm_out           <= 1'b0;
      signed_imm24_out  <= '0;
      dest_out          <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
      exe_cmd_out       <= '0;
      mem_r_en_out      <= 1'b0;
      mem_w_en_out      <= 1'b0;
      wb_en_out         <= 1'b0;
      b_out             <= 1'b0;
      s_out             <= 1'b0;
      carry_out         <= 1'b0;
      bubble_cnt        <= '0;
      stall_cnt         <= '0;
    end else if (flush) begin
      valid_out         <= 1'b0;
      pc_out            <= '0;
      val_rn_out        <= '0;
      val_rm_out        <= '0;
      shift_operand_out <= '0;
      imm_out           <= 1'b0;
      signed_imm24_out  <= '0;
      dest_out          <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
      exe_cmd_out       <= '0;
      mem_r_en_out      <= 1'b0;
      mem_w_en_out      <= 1'b0;
      wb_en_out         <= 1'b0;
      b_out             <= 1'b0;
      s_out             <= 1'b0;
      carry_out         <= 1'b0;
      if (bubble_cnt != '1) begin
        bubble_cnt <= bubble_cnt + CNT_ONE;
      end
    end else if (freeze) begin
      if (stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
    end else begin
      // Control bits load unconditionally; decode zeroes them for invalid slots.
      valid_out         <= valid_in;
      pc_out            <= pc_in;
      val_rn_out        <= val_rn_in;
      val_rm_out        <= val_rm_in;
      shift_operand_out <= shift_operand_in;
      imm_out           <= imm_in;
      signed_imm24_out  <= signed_imm24_in;
      dest_out          <= dest_in;
      src1_out          <= src1_in;
      src2_out          <= src2_in;
      exe_cmd_out       <= exe_cmd_in;
      mem_r_en_out      <= mem_r_en_in;
      mem_w_en_out      <= mem_w_en_in;
      wb_en_out         <= wb_en_in;
      b_out             <= b_in;
      s_out             <= s_in;
      carry_out         <= carry_in;
    end
  end

  // Derived only from registered bits, so it is stable for the whole cycle.
  assign is_mem_cmd_out = mem_r_en_out | mem_w_en_out;

endmodule

// File: tb/tb_id_exe_reg.sv
// tb/tb_id_exe_reg.sv - scoreboard testbench for id_exe_reg
module tb_id_exe_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, val_rn, val_rm;
    logic [11:0] shift;
    logic        imm;
    logic [23:0] simm;
    logic [3:0]  dest, src1, src2, exe;
    logic        mem_r, mem_w, wb, b, s, carry;
  } in_t;

  typedef struct {
    logic [156:0] vec;
    logic [15:0]  bub;
    logic [15:0]  stl;
    logic [3:0]   bub_s;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, freeze, flush, valid_in, imm_in, mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, carry_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm24_in;
  logic [3:0]  dest_in, src1_in, src2_in, exe_cmd_in;

  logic valid_out, imm_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, carry_out, is_mem_cmd_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm24_out;
  logic [3:0]  dest_out, src1_out, src2_out, exe_cmd_out;
  logic [15:0] bubble_cnt, stall_cnt;

  logic valid_out_s, imm_out_s, mem_r_en_out_s, mem_w_en_out_s, wb_en_out_s, b_out_s, s_out_s, carry_out_s, is_mem_cmd_out_s;
  logic [31:0] pc_out_s, val_rn_out_s, val_rm_out_s;
  logic [11:0] shift_operand_out_s;
  logic [23:0] signed_imm24_out_s;
  logic [3:0]  dest_out_s, src1_out_s, src2_out_s, exe_cmd_out_s;
  logic [3:0]  bubble_cnt_s, stall_cnt_s;

  id_exe_reg u_dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .shift_operand_in(shift_operand_in), .imm_in(imm_in), .signed_imm24_in(signed_imm24_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .exe_cmd_in(exe_cmd_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in),
    .b_in(b_in), .s_in(s_in), .carry_in(carry_in),
    .valid_out(valid_out), .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .shift_operand_out(shift_operand_out), .imm_out(imm_out), .signed_imm24_out(signed_imm24_out),
    .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .exe_cmd_out(exe_cmd_out),
    .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out), .wb_en_out(wb_en_out),
    .b_out(b_out), .s_out(s_out), .carry_out(carry_out), .is_mem_cmd_out(is_mem_cmd_out),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  id_exe_reg #(.CNT_WIDTH(4)) u_small (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .shift_operand_in(shift_operand_in), .imm_in(imm_in), .signed_imm24_in(signed_imm24_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .exe_cmd_in(exe_cmd_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in),
    .b_in(b_in), .s_in(s_in), .carry_in(carry_in),
    .valid_out(valid_out_s), .pc_out(pc_out_s), .val_rn_out(val_rn_out_s), .val_rm_out(val_rm_out_s),
    .shift_operand_out(shift_operand_out_s), .imm_out(imm_out_s), .signed_imm24_out(signed_imm24_out_s),
    .dest_out(dest_out_s), .src1_out(src1_out_s), .src2_out(src2_out_s), .exe_cmd_out(exe_cmd_out_s),
    .mem_r_en_out(mem_r_en_out_s), .mem_w_en_out(mem_w_en_out_s), .wb_en_out(wb_en_out_s),
    .b_out(b_out_s), .s_out(s_out_s), .carry_out(carry_out_s), .is_mem_cmd_out(is_mem_cmd_out_s),
    .bubble_cnt(bubble_cnt_s), .stall_cnt(stall_cnt_s)
  );

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];
  logic [156:0] model_vec;
  logic [15:0]  model_bub, model_stl;
  logic [3:0]   model_bub_s;

  function automatic logic [156:0] exp_from_in(input in_t i);
    return {i.pc, i.val_rn, i.val_rm, i.shift, i.imm, i.simm, i.dest, i.src1, i.src2, i.exe,
            i.mem_r, i.mem_w, i.wb, i.b, i.s, i.carry, i.valid, i.mem_r | i.mem_w};
  endfunction

  function automatic logic [156:0] pack_out();
    return {pc_out, val_rn_out, val_rm_out, shift_operand_out, imm_out, signed_imm24_out,
            dest_out, src1_out, src2_out, exe_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out,
            b_out, s_out, carry_out, valid_out, is_mem_cmd_out};
  endfunction

  function automatic in_t zero_in();
    in_t z;
    z = '0;
    return z;
  endfunction

  function automatic in_t rand_in();
    in_t r;
    logic [31:0] t;
    r.valid  = 1'($urandom_range(0, 1));
    r.pc     = $urandom();
    r.val_rn = $urandom();
    r.val_rm = $urandom();
    t = $urandom();
    r.shift = t[11:0];
    r.simm  = {t[31:12], t[3:0]};
    t = $urandom();
    {r.dest, r.src1, r.src2, r.exe} = t[15:0];
    {r.imm, r.mem_r, r.mem_w, r.wb, r.b, r.s, r.carry} = t[22:16];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of stimulus and push what the slot must hold after the edge.
  task automatic apply(input in_t i, input logic fz, input logic fl);
    valid_in = i.valid; pc_in = i.pc; val_rn_in = i.val_rn; val_rm_in = i.val_rm;
    shift_operand_in = i.shift; imm_in = i.imm; signed_imm24_in = i.simm;
    dest_in = i.dest; src1_in = i.src1; src2_in = i.src2; exe_cmd_in = i.exe;
    mem_r_en_in = i.mem_r; mem_w_en_in = i.mem_w; wb_en_in = i.wb;
    b_in = i.b; s_in = i.s; carry_in = i.carry;
    freeze = fz; flush = fl;
    if (fl) begin
      model_vec = '0;
      if (model_bub != 16'hFFFF) model_bub = model_bub + 16'd1;
      if (model_bub_s != 4'hF) model_bub_s = model_bub_s + 4'd1;
    end else if (fz) begin
      if (model_stl != 16'hFFFF) model_stl = model_stl + 16'd1;
    end else begin
      model_vec = exp_from_in(i);
    end
    exp_q.push_back('{vec: model_vec, bub: model_bub, stl: model_stl, bub_s: model_bub_s});
  endtask

  task automatic test_reset();
    in_t i;
    exp_t e;
    // reset asserted from time 0
    #2;
    checks++;
    if ({pack_out(), bubble_cnt, stall_cnt} !== '0) begin
      errors++; $display("FAIL reset_initial got=%h required=0", {pack_out(), bubble_cnt, stall_cnt});
    end
    tick(); rst = 1'b1; tick();
    i = zero_in(); i.pc = 32'h10; i.wb = 1'b1; i.valid = 1'b1;
    apply(i, 1'b0, 1'b0); tick();
    e = exp_q.pop_front();
    checks++;
    if (pc_out !== 32'h10 || wb_en_out !== 1'b1 || pack_out() !== e.vec) begin
      errors++; $display("FAIL reset_preload got=%h required=%h", pack_out(), e.vec);
    end
    // mid-cycle reset: outputs clear without waiting for an edge
    rst = 1'b0; #1;
    checks++;
    if ({pack_out(), bubble_cnt, stall_cnt} !== '0 || is_mem_cmd_out !== 1'b0) begin
      errors++; $display("FAIL reset_midrun got=%h required=0", {pack_out(), bubble_cnt, stall_cnt});
    end
    model_vec = '0; model_bub = '0; model_stl = '0; model_bub_s = '0;
    #1 rst = 1'b1;
  endtask

  task automatic test_normal_load();
    in_t i;
    exp_t e;
    i = zero_in(); i.valid = 1'b1; i.pc = 32'h20; i.val_rm = 32'h8000_0001;
    i.shift = 12'h0E3; i.imm = 1'b1; i.exe = 4'h1; i.wb = 1'b1;
    apply(i, 1'b0, 1'b0); tick();
    e = exp_q.pop_front();
    checks++;
    if (pack_out() !== e.vec) begin
      errors++; $display("FAIL normal_load got=%h required=%h", pack_out(), e.vec);
    end
    checks++;
    if (valid_out !== 1'b1 || val_rm_out !== 32'h8000_0001 || shift_operand_out !== 12'h0E3) begin
      errors++; $display("FAIL normal_load_fields valid=%b rm=%h sh=%h required 1/80000001/0e3",
                         valid_out, val_rm_out, shift_operand_out);
    end
  endtask

  task automatic test_freeze();
    in_t i;
    exp_t e;
    i = zero_in(); i.valid = 1'b1; i.pc = 32'h24;
    for (int k = 1; k <= 3; k++) begin
      apply(i, 1'b1, 1'b0); tick();
      e = exp_q.pop_front();
      checks++;
      if (pc_out !== 32'h20 || pack_out() !== e.vec || stall_cnt !== e.stl) begin
        errors++; $display("FAIL freeze_hold_%0d pc=%h stall=%0d required pc=00000020 stall=%0d",
                           k, pc_out, stall_cnt, e.stl);
      end
    end
    checks++;
    if (stall_cnt !== 16'd3) begin
      errors++; $display("FAIL freeze_stall_cnt got=%0d required=3", stall_cnt);
    end
    apply(i, 1'b0, 1'b0); tick();
    e = exp_q.pop_front();
    checks++;
    if (pc_out !== 32'h24 || pack_out() !== e.vec) begin
      errors++; $display("FAIL freeze_release pc=%h required=00000024", pc_out);
    end
  endtask

  task automatic test_flush_freeze();
    in_t i;
    exp_t e;
    i = zero_in(); i.valid = 1'b1; i.mem_r = 1'b1; i.pc = 32'h28; i.dest = 4'h3;
    apply(i, 1'b0, 1'b0); tick();
    e = exp_q.pop_front();
    checks++;
    if (is_mem_cmd_out !== 1'b1 || pack_out() !== e.vec) begin
      errors++; $display("FAIL flush_preload is_mem=%b required=1", is_mem_cmd_out);
    end
    apply(i, 1'b1, 1'b1); tick();
    e = exp_q.pop_front();
    checks++;
    if (pack_out() !== '0 || pack_out() !== e.vec) begin
      errors++; $display("FAIL flush_bubble got=%h required=0", pack_out());
    end
    checks++;
    if (bubble_cnt !== 16'd1 || stall_cnt !== 16'd3) begin
      errors++; $display("FAIL flush_counters bubble=%0d stall=%0d required 1/3", bubble_cnt, stall_cnt);
    end
    // freeze still high next cycle: the bubble is held
    apply(rand_in(), 1'b1, 1'b0); tick();
    e = exp_q.pop_front();
    checks++;
    if (pack_out() !== '0 || stall_cnt !== 16'd4 || bubble_cnt !== e.bub) begin
      errors++; $display("FAIL flush_then_freeze got=%h stall=%0d required 0/4", pack_out(), stall_cnt);
    end
  endtask

  task automatic test_mem_cmd();
    in_t i;
    exp_t e;
    i = zero_in(); i.valid = 1'b1; i.mem_w = 1'b1; i.shift = 12'h804; i.src2 = 4'h7;
    apply(i, 1'b0, 1'b0); tick();
    e = exp_q.pop_front();
    checks++;
    if (is_mem_cmd_out !== 1'b1 || shift_operand_out !== 12'h804 || pack_out() !== e.vec) begin
      errors++; $display("FAIL mem_cmd is_mem=%b sh=%h required 1/804", is_mem_cmd_out, shift_operand_out);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int k = 0; k < 24; k++) begin
      apply(rand_in(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0)); tick();
      e = exp_q.pop_front();
      checks++;
      if (pack_out() !== e.vec || bubble_cnt !== e.bub || stall_cnt !== e.stl) begin
        errors++; $display("FAIL b2b_%0d got=%h b=%0d s=%0d required=%h b=%0d s=%0d",
                           k, pack_out(), bubble_cnt, stall_cnt, e.vec, e.bub, e.stl);
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    for (int k = 0; k < 20; k++) begin
      apply(rand_in(), 1'($urandom_range(0, 1)), 1'b1); tick();
      e = exp_q.pop_front();
      checks++;
      if (bubble_cnt_s !== e.bub_s || bubble_cnt !== e.bub || pack_out() !== '0) begin
        errors++; $display("FAIL sat_%0d small=%h main=%0d required small=%h main=%0d",
                           k, bubble_cnt_s, bubble_cnt, e.bub_s, e.bub);
      end
    end
    checks++;
    if (bubble_cnt_s !== 4'hF) begin
      errors++; $display("FAIL sat_final got=%h required=f", bubble_cnt_s);
    end
  endtask

  initial begin
    rst = 1'b0;
    model_vec = '0; model_bub = '0; model_stl = '0; model_bub_s = '0;
    valid_in = 0; pc_in = 0; val_rn_in = 0; val_rm_in = 0; shift_operand_in = 0; imm_in = 0;
    signed_imm24_in = 0; dest_in = 0; src1_in = 0; src2_in = 0; exe_cmd_in = 0;
    mem_r_en_in = 0; mem_w_en_in = 0; wb_en_in = 0; b_in = 0; s_in = 0; carry_in = 0;
    freeze = 0; flush = 0;
    test_reset();
    test_normal_load();
    test_freeze();
    test_flush_freeze();
    test_mem_cmd();
    test_back_to_back();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/id_exe_reg.md
Name: id_exe_reg

Overview:
- Pipeline register between the instruction-decode stage and the execute stage of the ARM-subset core.
- Captures decoded operands and control each cycle and presents them to the execute stage: ALU, val2 generation and branch-target adder.
- Supports a freeze (load-use hazard stall) and a flush (taken branch), and tracks slot validity.
- Keeps two saturating event counters for performance debug.

Parameters:
- WORD_WIDTH, 32, datapath width (pc, register values).
- SHIFTER_OPERAND_WIDTH, 12, width of shifter operand field.
- REG_ADDR_WIDTH, 4, register file address width.
- EXE_CMD_WIDTH, 4, ALU command width.
- CNT_WIDTH, 16, width of debug event counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- freeze  in  1  hold all stage contents (hazard stall).
- flush  in  1  replace next stage contents with a bubble.
- valid_in  in  1  decode stage holds a real instruction.
- pc_in  in  WORD_WIDTH  instruction pc+4.
- val_rn_in, val_rm_in  in  WORD_WIDTH  register file read values.
- shift_operand_in  in  SHIFTER_OPERAND_WIDTH  instr[11:0].
- imm_in  in  1  I bit.
- signed_imm24_in  in  24  branch offset.
- dest_in, src1_in, src2_in  in  REG_ADDR_WIDTH  destination and source register numbers, used by forwarding.
- exe_cmd_in  in  EXE_CMD_WIDTH  ALU operation.
- mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in  in  1  control bits.
- carry_in  in  1  status register C flag.
- Each *_in above has a matching *_out (same width, out) driven from the register.
- valid_out  out  1  execute slot holds a real instruction.
- is_mem_cmd_out  out  1  equals mem_r_en_out OR mem_w_en_out (combinational from registered bits).
- bubble_cnt  out  CNT_WIDTH  number of bubbles inserted by flush.
- stall_cnt  out  CNT_WIDTH  number of cycles frozen.

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - all *_out registers, valid_out, bubble_cnt and stall_cnt go to 0;
  - is_mem_cmd_out therefore reads 0.
  - Release is synchronous to the next clk edge, with no glitch on outputs.
- Per rising edge, mutually exclusive, priority order:
  1. flush=1 (regardless of freeze):
     - control outputs cleared: wb_en, mem_r_en, mem_w_en, b, s = 0; exe_cmd = 0; valid_out = 0;
     - data outputs cleared: pc, val_rn, val_rm, shift_operand, imm, signed_imm24, dest, src1, src2, carry = 0;
     - bubble_cnt += 1.
  2. freeze=1, flush=0:
     - every output register holds its value;
     - stall_cnt += 1.
  3. otherwise:
     - every *_out <= *_in;
     - valid_out <= valid_in.
     - If valid_in=0, control bits are still loaded as presented; decode guarantees they are 0.
- Counters saturate at all-ones; they never wrap.
- Flush during freeze:
  - flush wins, bubble is inserted, stall_cnt is not incremented.
  - On the following cycle, if freeze is still 1, the bubble is held.
- Latency: one cycle from *_in to *_out. No combinational path from any input to any output.
- Freeze deasserting: the value present on *_in at the first non-frozen edge is captured; decode holds its outputs stable while frozen.
- Back-to-back flushes: each edge inserts a bubble; bubble_cnt increments every edge.
- shift_operand_out, imm_out, val_rm_out and is_mem_cmd_out feed the val2 generator directly. They must be stable for the whole cycle.
- No X propagation: all registers are reset, and no output depends on an unreset state.

Test Plan:
- Reset mid-run: load pc_in=0x0000_0010, wb_en_in=1, then pull rst=0 between edges -> all outputs 0 immediately, counters 0, is_mem_cmd_out=0.
- Normal load: valid_in=1, pc_in=0x0000_0020, val_rm_in=0x8000_0001, shift_operand_in=0x0E3, imm_in=1, exe_cmd_in=0x1, wb_en_in=1 -> next edge outputs equal inputs, valid_out=1.
- Freeze: after loading pc=0x20, hold freeze=1 for 3 edges while pc_in=0x24 -> pc_out stays 0x20, stall_cnt=3; at the first edge after freeze drops, pc_out=0x24.
- Flush with freeze: load mem_r_en_in=1 (is_mem_cmd_out=1), then freeze=1 and flush=1 on one edge -> all outputs 0, valid_out=0, is_mem_cmd_out=0, bubble_cnt=1, stall_cnt unchanged.
- Counter saturation: CNT_WIDTH=4 override, 20 consecutive flush edges -> bubble_cnt=0xF and stays 0xF.
- Mem command: mem_w_en_in=1, mem_r_en_in=0, shift_operand_in=0x804 -> next edge is_mem_cmd_out=1, shift_operand_out=0x804.
